// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/breakpoint controller producing a CPU clock-enable
// Debounced single-step, free-running/slow run, PC breakpoint and a hard cycle limit.
module cpu_run_ctrl #(
  parameter int CYCLE_LIMIT = 2048,
  parameter int DIV_WIDTH   = 24,
  parameter int DEB_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        run_sw,
  input  logic        fast_sw,
  input  logic        step_btn,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  output logic        cpu_ce,
  output logic [31:0] cycle_cnt,
  output logic [1:0]  state,
  output logic        halted
);

  localparam int              DCW      = $clog2(DEB_CYCLES + 1);
  localparam logic [31:0]     LIMIT    = 32'(CYCLE_LIMIT);
  localparam logic [DCW-1:0]  DEB_LAST = DCW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STEP = 2'd2, HALT = 2'd3} state_t;

  state_t               cur;
  logic                 sync1, sync2;
  logic                 deb_level, deb_prev;
  logic [DCW-1:0]       deb_cnt;
  logic [DIV_WIDTH-1:0] div;
  logic                 armed;
  logic                 step_req, tick, bp_hit, at_limit, below_limit;

  // deb_cnt counts consecutive samples disagreeing with the accepted level
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync1    <= step_btn;
      sync2    <= sync1;
      deb_prev <= deb_level;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_level <= sync2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) div <= '0;
    else       div <= div + 1'b1;
  end

  assign step_req    = deb_level & ~deb_prev;
  assign tick        = fast_sw | (&div);
  assign bp_hit      = armed & bp_en & (pc == bp_addr);
  assign at_limit    = (cycle_cnt == LIMIT);
  assign below_limit = (cycle_cnt < LIMIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur       <= IDLE;
      cpu_ce    <= 1'b0;
      cycle_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      cpu_ce <= 1'b0;
      case (cur)
        IDLE: begin
          if (run_sw) begin
            cur   <= RUN;
            armed <= 1'b0;
          end else if (step_req) begin
            cur <= STEP;
          end
        end
        RUN: begin
          if (at_limit) begin
            cur <= HALT;
          end else if (!run_sw) begin
            cur <= IDLE;
          end else if (tick) begin
            if (bp_hit) begin
              cur <= HALT;
            end else if (below_limit) begin
              cpu_ce    <= 1'b1;
              cycle_cnt <= cycle_cnt + 32'd1;
              armed     <= 1'b1;
            end
          end
        end
        STEP: begin
          if (below_limit) begin
            cpu_ce    <= 1'b1;
            cycle_cnt <= cycle_cnt + 32'd1;
          end
          cur <= IDLE;
        end
        HALT: begin
          // the limit halt can only be left through reset
          if (!at_limit) begin
            if (!run_sw)       cur <= IDLE;
            else if (step_req) cur <= STEP;
          end
        end
        default: cur <= IDLE;
      endcase
    end
  end

  assign state  = cur;
  assign halted = (cur == HALT);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        run_sw = 1'b0;
  logic        fast_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        cpu_ce;
  logic [31:0] cycle_cnt;
  logic [1:0]  state;
  logic        halted;

  int errors = 0;
  int checks = 0;

  cpu_run_ctrl #(.CYCLE_LIMIT(2048), .DIV_WIDTH(4), .DEB_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn), .run_sw(run_sw), .fast_sw(fast_sw), .step_btn(step_btn),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_ce(cpu_ce), .cycle_cnt(cycle_cnt),
    .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; run_sw = 1'b0; fast_sw = 1'b0; step_btn = 1'b0;
    bp_en = 1'b0; bp_addr = 32'd0; pc = 32'd0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got=%b exp=0", cpu_ce); end
    checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cycle_cnt); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
  endtask

  task automatic test_limit();
    int pulses = 0;
    do_reset();
    fast_sw = 1'b1; run_sw = 1'b1;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (cpu_ce) pulses++;
    end
    checks++; if (pulses !== 2048) begin errors++; $display("FAIL limit_pulses got=%0d exp=2048", pulses); end
    checks++; if (cycle_cnt !== 32'd2048) begin errors++; $display("FAIL limit_cnt got=%0d exp=2048", cycle_cnt); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL limit_halted got=%b exp=1", halted); end
    pulses = 0;
    run_sw = 1'b0;
    repeat (5) begin @(negedge clk); if (cpu_ce) pulses++; end
    run_sw = 1'b1;
    repeat (5) begin @(negedge clk); if (cpu_ce) pulses++; end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL limit_sticky got=%0d exp=3", state); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL limit_no_pulse got=%0d exp=0", pulses); end
  endtask

  task automatic test_debounce();
    int pulses = 0;
    do_reset();
    fast_sw = 1'b1;
    for (int b = 0; b < 3; b++) begin
      step_btn = 1'b1;
      repeat (5) begin @(negedge clk); if (cpu_ce) pulses++; end
      step_btn = 1'b0;
      repeat (5) begin @(negedge clk); if (cpu_ce) pulses++; end
    end
    step_btn = 1'b1;
    repeat (40) begin @(negedge clk); if (cpu_ce) pulses++; end
    step_btn = 1'b0;
    repeat (40) begin @(negedge clk); if (cpu_ce) pulses++; end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL deb_pulses got=%0d exp=1", pulses); end
    checks++; if (cycle_cnt !== 32'd1) begin errors++; $display("FAIL deb_cnt got=%0d exp=1", cycle_cnt); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL deb_state got=%0d exp=0", state); end
  endtask

  task automatic test_breakpoint();
    int pulses = 0;
    bit seen = 1'b0;
    do_reset();
    bp_en = 1'b1; bp_addr = 32'h0000_0010; fast_sw = 1'b1; run_sw = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (cycle_cnt == 32'd4) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_reach4 got=%0d exp=4 (timeout)", cycle_cnt); end
    pc = 32'h0000_0010;
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL bp_state got=%0d exp=3", state); end
    checks++; if (cycle_cnt !== 32'd4) begin errors++; $display("FAIL bp_cnt got=%0d exp=4", cycle_cnt); end
    run_sw = 1'b0;
    @(negedge clk);
    run_sw = 1'b1;
    repeat (10) begin @(negedge clk); if (cpu_ce) pulses++; end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL bp_resume_pulses got=%0d exp=1", pulses); end
    checks++; if (cycle_cnt !== 32'd5) begin errors++; $display("FAIL bp_resume_cnt got=%0d exp=5", cycle_cnt); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL bp_rehalt got=%0d exp=3", state); end
  endtask

  task automatic test_slow_div();
    int times[$];
    do_reset();
    run_sw = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (cpu_ce) times.push_back(i);
    end
    checks++; if (times.size() < 4) begin errors++; $display("FAIL slow_count got=%0d exp>=4", times.size()); end
    for (int k = 1; k < times.size(); k++) begin
      checks++;
      if (times[k] - times[k-1] !== 16) begin
        errors++; $display("FAIL slow_gap%0d got=%0d exp=16", k, times[k] - times[k-1]);
      end
    end
    fast_sw = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL fast_ce%0d got=%b exp=1", k, cpu_ce); end
    end
  endtask

  task automatic test_async_reset();
    bit seen = 1'b0;
    do_reset();
    fast_sw = 1'b1; run_sw = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (cycle_cnt == 32'd7) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ar_reach7 got=%0d exp=7 (timeout)", cycle_cnt); end
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL ar_ce_before got=%b exp=1", cpu_ce); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL ar_ce got=%b exp=0", cpu_ce); end
    checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL ar_cnt got=%0d exp=0", cycle_cnt); end
    run_sw = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL ar_state got=%0d exp=0", state); end
  endtask

  task automatic test_run_step_same();
    do_reset();
    step_btn = 1'b1;
    repeat (18) @(negedge clk);
    run_sw = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rs_state got=%0d exp=1", state); end
    checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL rs_cnt got=%0d exp=0", cycle_cnt); end
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rs_state2 got=%0d exp=1", state); end
  endtask

  initial begin
    test_reset();
    test_limit();
    test_debounce();
    test_breakpoint();
    test_slow_div();
    test_async_reset();
    test_run_step_same();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
